// File: rtl/parking_pkg.sv
// Shared definitions for the parking exit gate: FSM encoding, exit code and
// the 7-segment digit table.
package parking_pkg;

  typedef enum logic [2:0] {
    StIdle       = 3'b000,
    StWaitTicket = 3'b001,
    StDenied     = 3'b010,
    StPaid       = 3'b011,
    StHold       = 3'b100
  } state_e;

  localparam logic [1:0] CodeDigit1 = 2'b10;
  localparam logic [1:0] CodeDigit2 = 2'b01;

  localparam logic [6:0] SegBlank = 7'h7f;

  // Active-low segments, bit 6 = g ... bit 0 = a; entry [d] is digit d.
  localparam logic [9:0][6:0] Seg7Table = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes blank the digit.
module seg7_decoder
  import parking_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SegBlank;
    if (bcd_i <= 4'd9) begin
      seg_o = Seg7Table[bcd_i];
    end
  end

endmodule

// File: rtl/parking_exit_gate.sv
// Exit barrier controller: ticket-checking Moore FSM, occupancy counter and a
// two-digit free-bay display.
module parking_exit_gate
  import parking_pkg::*;
#(
  parameter int unsigned CAPACITY    = 20,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       car_entered,
  input  logic       sensor_exit,
  input  logic       sensor_clear,
  input  logic [1:0] ticket_1,
  input  logic [1:0] ticket_2,
  output logic       GREEN_LED,
  output logic       RED_LED,
  output logic       GATE_OPEN,
  output logic       FULL,
  output logic [6:0] occupancy,
  output logic [6:0] HEX_1,
  output logic [6:0] HEX_2
);

  localparam int unsigned WaitW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_CYCLES);
  localparam logic [6:0] Cap = 7'(CAPACITY);

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [6:0]       occ_q, occ_d;
  logic             tgl_q, tgl_d;
  logic [3:0]       ones_q, ones_d, tens_q, tens_d;
  logic [6:0]       free_bays;
  logic             code_ok;
  logic             exit_done;

  assign code_ok = (ticket_1 == CodeDigit1) && (ticket_2 == CodeDigit2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      wait_q  <= '0;
      occ_q   <= '0;
      tgl_q   <= 1'b0;
      ones_q  <= 4'(CAPACITY % 10);
      tens_q  <= 4'(CAPACITY / 10);
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      occ_q   <= occ_d;
      tgl_q   <= tgl_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    exit_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (sensor_exit && (occ_q != 7'd0)) state_d = StWaitTicket;
      end
      StWaitTicket: begin
        if (wait_q == WaitLast) begin
          state_d = code_ok ? StPaid : StDenied;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDenied: begin
        if (code_ok) begin
          state_d = StPaid;
        end else if (!sensor_exit) begin
          state_d = StIdle;
        end
      end
      StPaid: begin
        // A second car at the barrier while the first clears is a tailgate.
        if (sensor_exit && sensor_clear) begin
          state_d = StHold;
        end else if (sensor_clear) begin
          state_d   = StIdle;
          exit_done = 1'b1;
        end
      end
      StHold: begin
        if (code_ok) state_d = StPaid;
      end
      default: state_d = StIdle;
    endcase
  end

  assign tgl_d = (state_q == StHold) ? ~tgl_q : 1'b0;

  always_comb begin
    GREEN_LED = 1'b0;
    RED_LED   = 1'b0;
    GATE_OPEN = 1'b0;
    case (state_q)
      StWaitTicket: RED_LED = 1'b1;
      StDenied:     RED_LED = 1'b1;
      StPaid: begin
        GREEN_LED = 1'b1;
        GATE_OPEN = 1'b1;
      end
      StHold:       RED_LED = ~tgl_q;
      default: ;
    endcase
  end

  // An entry and an exit in the same cycle cancel, even when full.
  always_comb begin
    occ_d = occ_q;
    if (car_entered && !exit_done) begin
      if (occ_q < Cap) occ_d = occ_q + 7'd1;
    end else if (exit_done && !car_entered) begin
      if (occ_q != 7'd0) occ_d = occ_q - 7'd1;
    end
  end

  assign free_bays = Cap - occ_q;
  assign ones_d    = 4'(free_bays % 7'd10);
  assign tens_d    = 4'(free_bays / 7'd10);

  assign occupancy = occ_q;
  assign FULL      = (occ_q == Cap);

  seg7_decoder u_seg_ones (
    .bcd_i (ones_q),
    .seg_o (HEX_1)
  );

  seg7_decoder u_seg_tens (
    .bcd_i (tens_q),
    .seg_o (HEX_2)
  );

endmodule

// File: tb/tb_parking_exit_gate.sv
// Self-checking bench for parking_exit_gate: default instance plus a
// CAPACITY=2 instance sharing the same stimulus.
module tb_parking_exit_gate;

  logic       clk, reset_n, car_entered, sensor_exit, sensor_clear;
  logic [1:0] ticket_1, ticket_2;
  logic       green, red, gate, full;
  logic [6:0] occ, hex1, hex2;
  logic       green2, red2, gate2, full2;
  logic [6:0] occ2, hex1_2, hex2_2;

  int total = 0;
  int bad   = 0;
  int m_occ, m_occ2;
  int exp_q[$];
  int exp2_q[$];
  int e;

  parking_exit_gate u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .car_entered  (car_entered),
    .sensor_exit  (sensor_exit),
    .sensor_clear (sensor_clear),
    .ticket_1     (ticket_1),
    .ticket_2     (ticket_2),
    .GREEN_LED    (green),
    .RED_LED      (red),
    .GATE_OPEN    (gate),
    .FULL         (full),
    .occupancy    (occ),
    .HEX_1        (hex1),
    .HEX_2        (hex2)
  );

  parking_exit_gate #(.CAPACITY(2)) u_dut2 (
    .clk          (clk),
    .reset_n      (reset_n),
    .car_entered  (car_entered),
    .sensor_exit  (sensor_exit),
    .sensor_clear (sensor_clear),
    .ticket_1     (ticket_1),
    .ticket_2     (ticket_2),
    .GREEN_LED    (green2),
    .RED_LED      (red2),
    .GATE_OPEN    (gate2),
    .FULL         (full2),
    .occupancy    (occ2),
    .HEX_1        (hex1_2),
    .HEX_2        (hex2_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    car_entered = 0; sensor_exit = 0; sensor_clear = 0; ticket_1 = 0; ticket_2 = 0;
    reset_n = 0;
    step(2);
    reset_n = 1;
    m_occ = 0; m_occ2 = 0;
    exp_q.delete(); exp2_q.delete();
  endtask

  // One car_entered pulse; expected occupancies queued before the edge.
  task automatic drive_car();
    car_entered = 1;
    m_occ  = (m_occ  < 20) ? m_occ  + 1 : m_occ;
    m_occ2 = (m_occ2 < 2)  ? m_occ2 + 1 : m_occ2;
    exp_q.push_back(m_occ);
    exp2_q.push_back(m_occ2);
    step(1);
    car_entered = 0;
  endtask

  task automatic test_reset();
    car_entered = 0; sensor_exit = 0; sensor_clear = 0; ticket_1 = 0; ticket_2 = 0;
    reset_n = 1;
    step(1);
    #2 reset_n = 0;
    #1;
    total++;
    if ({green, red, gate, full} !== 4'b0000 || occ !== 7'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b occ=%0d want=0000 occ=0", {green, red, gate, full}, occ);
    end
    total++;
    if (hex2 !== seg_ref(2) || hex1 !== seg_ref(0)) begin
      bad++;
      $display("FAIL reset_hex got=%h/%h want=%h/%h", hex2, hex1, seg_ref(2), seg_ref(0));
    end
    total++;
    if (hex2_2 !== seg_ref(0) || hex1_2 !== seg_ref(2) || full2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_hex_cap2 got=%h/%h full=%b want=%h/%h full=0",
               hex2_2, hex1_2, full2, seg_ref(0), seg_ref(2));
    end
    step(1);
    reset_n = 1;
  endtask

  task automatic test_paid_exit();
    do_reset();
    repeat (3) begin
      drive_car();
      e = exp_q.pop_front();
      void'(exp2_q.pop_front());
      total++;
      if (occ !== 7'(e)) begin
        bad++;
        $display("FAIL entry_count got=%0d want=%0d", occ, e);
      end
    end
    step(1);
    total++;
    if (hex2 !== seg_ref(1) || hex1 !== seg_ref(7)) begin
      bad++;
      $display("FAIL hex_17 got=%h/%h want=%h/%h", hex2, hex1, seg_ref(1), seg_ref(7));
    end
    ticket_1 = 2'b10; ticket_2 = 2'b01; sensor_exit = 1;
    step(5);
    total++;
    if ({green, red, gate} !== 3'b010) begin
      bad++;
      $display("FAIL wait_window got=%b want=010", {green, red, gate});
    end
    step(1);
    total++;
    if ({green, red, gate} !== 3'b101) begin
      bad++;
      $display("FAIL paid_6th got=%b want=101", {green, red, gate});
    end
    sensor_exit = 0; sensor_clear = 1;
    m_occ = m_occ - 1;
    exp_q.push_back(m_occ);
    step(1);
    sensor_clear = 0;
    e = exp_q.pop_front();
    total++;
    if (occ !== 7'(e) || {green, red, gate} !== 3'b000) begin
      bad++;
      $display("FAIL exit_done got occ=%0d leds=%b want occ=%0d leds=000", occ, {green, red, gate}, e);
    end
    step(1);
    total++;
    if (hex2 !== seg_ref(1) || hex1 !== seg_ref(8)) begin
      bad++;
      $display("FAIL hex_18 got=%h/%h want=%h/%h", hex2, hex1, seg_ref(1), seg_ref(8));
    end
  endtask

  task automatic test_denied();
    do_reset();
    drive_car();
    void'(exp_q.pop_front()); void'(exp2_q.pop_front());
    ticket_1 = 2'b00; ticket_2 = 2'b00; sensor_exit = 1;
    step(6);
    total++;
    if ({green, red, gate} !== 3'b010) begin
      bad++;
      $display("FAIL denied got=%b want=010", {green, red, gate});
    end
    step(1);
    total++;
    if ({green, red, gate} !== 3'b010) begin
      bad++;
      $display("FAIL denied_stay got=%b want=010", {green, red, gate});
    end
    ticket_1 = 2'b10; ticket_2 = 2'b01;
    step(1);
    total++;
    if ({green, red, gate} !== 3'b101) begin
      bad++;
      $display("FAIL denied_to_paid got=%b want=101", {green, red, gate});
    end
    sensor_exit = 0; ticket_1 = 2'b00; ticket_2 = 2'b00;
    step(1);
    total++;
    if ({green, red, gate} !== 3'b101) begin
      bad++;
      $display("FAIL paid_stay got=%b want=101", {green, red, gate});
    end
    // Reversal out of DENIED
    do_reset();
    drive_car();
    e = exp_q.pop_front(); void'(exp2_q.pop_front());
    sensor_exit = 1;
    step(6);
    sensor_exit = 0;
    step(1);
    total++;
    if ({green, red, gate} !== 3'b000 || occ !== 7'(e)) begin
      bad++;
      $display("FAIL reverse got leds=%b occ=%0d want leds=000 occ=%0d", {green, red, gate}, occ, e);
    end
  endtask

  task automatic test_hold();
    do_reset();
    drive_car();
    e = exp_q.pop_front(); void'(exp2_q.pop_front());
    ticket_1 = 2'b10; ticket_2 = 2'b01; sensor_exit = 1;
    step(6);
    ticket_1 = 2'b00; ticket_2 = 2'b00; sensor_clear = 1;
    step(1);
    total++;
    if ({green, red, gate} !== 3'b010) begin
      bad++;
      $display("FAIL hold_enter got=%b want=010", {green, red, gate});
    end
    sensor_exit = 0; sensor_clear = 0;
    step(1);
    total++;
    if ({green, red, gate} !== 3'b000) begin
      bad++;
      $display("FAIL hold_toggle0 got=%b want=000", {green, red, gate});
    end
    step(1);
    total++;
    if (red !== 1'b1 || occ !== 7'(e)) begin
      bad++;
      $display("FAIL hold_toggle1 got red=%b occ=%0d want red=1 occ=%0d", red, occ, e);
    end
    ticket_1 = 2'b10; ticket_2 = 2'b01;
    step(1);
    total++;
    if ({green, red, gate} !== 3'b101) begin
      bad++;
      $display("FAIL hold_to_paid got=%b want=101", {green, red, gate});
    end
  endtask

  task automatic test_capacity();
    do_reset();
    repeat (3) begin
      drive_car();
      void'(exp_q.pop_front());
      e = exp2_q.pop_front();
      total++;
      if (occ2 !== 7'(e)) begin
        bad++;
        $display("FAIL cap2_count got=%0d want=%0d", occ2, e);
      end
    end
    step(1);
    total++;
    if (full2 !== 1'b1 || hex2_2 !== seg_ref(0) || hex1_2 !== seg_ref(0)) begin
      bad++;
      $display("FAIL cap2_full got full=%b hex=%h/%h want full=1 hex=%h/%h",
               full2, hex2_2, hex1_2, seg_ref(0), seg_ref(0));
    end
    ticket_1 = 2'b10; ticket_2 = 2'b01; sensor_exit = 1;
    step(6);
    total++;
    if (green2 !== 1'b1) begin
      bad++;
      $display("FAIL cap2_paid got=%b want=1", green2);
    end
    sensor_exit = 0; sensor_clear = 1; car_entered = 1;
    exp2_q.push_back(m_occ2);
    exp_q.push_back(m_occ);
    step(1);
    sensor_clear = 0; car_entered = 0;
    e = exp2_q.pop_front();
    total++;
    if (occ2 !== 7'(e) || full2 !== 1'b1 || green2 !== 1'b0) begin
      bad++;
      $display("FAIL cap2_simul got occ=%0d full=%b green=%b want occ=%0d full=1 green=0",
               occ2, full2, green2, e);
    end
    e = exp_q.pop_front();
    total++;
    if (occ !== 7'(e)) begin
      bad++;
      $display("FAIL simul_main got=%0d want=%0d", occ, e);
    end
  endtask

  task automatic test_empty_ignore();
    do_reset();
    ticket_1 = 2'b10; ticket_2 = 2'b01; sensor_exit = 1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      total++;
      if ({green, red, gate, full} !== 4'b0000 || occ !== 7'd0) begin
        bad++;
        $display("FAIL empty_ignore cyc=%0d got=%b occ=%0d want=0000 occ=0",
                 i, {green, red, gate, full}, occ);
      end
    end
    sensor_exit = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_car();
    void'(exp_q.pop_front()); void'(exp2_q.pop_front());
    ticket_1 = 2'b10; ticket_2 = 2'b01; sensor_exit = 1;
    step(6);
    total++;
    if (gate !== 1'b1) begin
      bad++;
      $display("FAIL async_pre got gate=%b want=1", gate);
    end
    sensor_exit = 0; sensor_clear = 1;
    #2 reset_n = 0;
    #1;
    total++;
    if (gate !== 1'b0 || green !== 1'b0 || occ !== 7'd0) begin
      bad++;
      $display("FAIL async_reset got gate=%b green=%b occ=%0d want 0 0 0", gate, green, occ);
    end
    step(1);
    reset_n = 1;
    step(1);
    sensor_clear = 0;
    total++;
    if (occ !== 7'd0 || hex2 !== seg_ref(2) || hex1 !== seg_ref(0)) begin
      bad++;
      $display("FAIL async_after got occ=%0d hex=%h/%h want occ=0 hex=%h/%h",
               occ, hex2, hex1, seg_ref(2), seg_ref(0));
    end
  endtask

  initial begin
    test_reset();
    test_paid_exit();
    test_denied();
    test_hold();
    test_capacity();
    test_empty_ignore();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parking_exit_gate.md
PARKING_EXIT_GATE -- requirements
Module: parking_exit_gate

Interface
REQ-001 SHALL have parameter CAPACITY, default 20, meaning total bays; legal range 1..99.
REQ-002 SHALL have parameter WAIT_CYCLES, default 4, meaning ticket-entry window length in clocks.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port car_entered  input  1  one-cycle pulse per car admitted by the entrance gate.
REQ-006 SHALL have port sensor_exit  input  1  car present at exit barrier.
REQ-007 SHALL have port sensor_clear  input  1  car has passed beyond exit barrier.
REQ-008 SHALL have port ticket_1  input  2  first exit-code digit.
REQ-009 SHALL have port ticket_2  input  2  second exit-code digit.
REQ-010 SHALL have port GREEN_LED  output  1  exit permitted.
REQ-011 SHALL have port RED_LED  output  1  exit refused or pending.
REQ-012 SHALL have port GATE_OPEN  output  1  barrier actuator.
REQ-013 SHALL have port FULL  output  1  occupancy == CAPACITY.
REQ-014 SHALL have port occupancy  output  7  cars currently parked.
REQ-015 SHALL have port HEX_1  output  7  free-bay ones digit, active-low segments (g..a).
REQ-016 SHALL have port HEX_2  output  7  free-bay tens digit, active-low segments (g..a).

Function
REQ-017 SHALL implement a Moore FSM, states IDLE, WAIT_TICKET, DENIED, PAID, HOLD; LED/gate outputs decoded from current state only.
REQ-018 IDLE -> WAIT_TICKET when sensor_exit=1 and occupancy>0; sensor_exit with occupancy==0 SHALL be ignored.
REQ-019 WAIT_TICKET SHALL run a wait counter, cleared in every other state; after WAIT_CYCLES+1 cycles in state, go PAID if ticket_1==2'b10 and ticket_2==2'b01, else DENIED.
REQ-020 DENIED -> PAID on correct code; DENIED -> IDLE when sensor_exit=0 (car reversed away); otherwise stay.
REQ-021 PAID: sensor_exit=1 and sensor_clear=1 same cycle (tailgate) -> HOLD; sensor_clear=1 alone -> IDLE with exit completion; otherwise stay.
REQ-022 HOLD -> PAID on correct code; otherwise stay; no occupancy change.
REQ-023 Outputs: IDLE all 0; WAIT_TICKET RED=1; DENIED RED=1; PAID GREEN=1, GATE_OPEN=1; HOLD RED toggles every clock, GATE_OPEN=0.
REQ-024 occupancy SHALL increment on car_entered when < CAPACITY, saturating at CAPACITY (pulse dropped).
REQ-025 occupancy SHALL decrement on exit completion (PAID -> IDLE transition), never below 0.
REQ-026 Simultaneous car_entered and exit completion SHALL leave occupancy unchanged, including when FULL.
REQ-027 HEX_1/HEX_2 SHALL show (CAPACITY - occupancy) in decimal, updating the cycle after occupancy changes; tens digit 0 shown as 0.
REQ-028 FULL SHALL be combinational from registered occupancy.

Reset
REQ-029 reset_n=0 SHALL immediately force state IDLE, wait counter 0, occupancy 0, HOLD toggle 0, independent of clk.
REQ-030 During and after reset: LEDs and GATE_OPEN 0, FULL 0, HEX shows CAPACITY (default "20"); a car mid-exit is discarded without decrement.

Structure
REQ-031 Shared package parking_pkg SHALL hold the state encoding (3 bits, IDLE=3'b000), exit-code constants 2'b10/2'b01, and the 7-segment digit table.
REQ-032 One sub-module seg7_decoder (4-bit BCD in, 7-bit active-low out) SHALL be instantiated twice.

Verification
REQ-033 Reset, 3 car_entered pulses, sensor_exit=1, code 10/01 held -> PAID on 6th cycle after exit; sensor_clear -> occupancy 3->2, HEX "18".
REQ-034 Wrong code 00/00 at window end -> DENIED, RED=1; code becomes 10/01 -> next cycle PAID, GREEN=1.
REQ-035 In PAID drive sensor_exit=1, sensor_clear=1 -> HOLD, RED toggles, occupancy unchanged; correct code -> PAID.
REQ-036 CAPACITY=2: 3 car_entered pulses -> occupancy 2, FULL=1, HEX "00"; exit completion same cycle as car_entered -> occupancy stays 2.
REQ-037 occupancy=0, sensor_exit=1 for 10 cycles -> state stays IDLE, all outputs 0.
REQ-038 reset_n low mid-PAID, asynchronous to clk -> GATE_OPEN 0 at once, occupancy 0.
